seg_serial_driver: RTL and testbench

Serial seven-segment output stage feeding the board's 74HC595-style segment shift chain through SEGCLK/SEGCLR/SEGDT/SEGEN. It sits inside `top` directly upstream of those four pins. It accepts a 64-bit segment frame (8 digits × 8 segments) from the display formatter over a valid/ready handshake. It shifts the frame out MSB-first on a divided serial clock, then pulses the latch enable.

---
 rtl/seg_serial_driver.sv | 122 ++++++++++++
 tb/tb_seg_serial_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_driver.sv
// Serial seven-segment driver: shifts a frame MSB-first into a 74HC595-style chain, then pulses SEGEN.
// Optional SEG_AUTO_REFRESH_EN: re-send the held frame whenever no new frame is offered.
module seg_serial_driver #(
    parameter int CLK_DIV = 4,
    parameter int NBITS   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] frame_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             SEGCLK,
    output logic             SEGCLR,
    output logic             SEGDT,
    output logic             SEGEN
);
    // state    | meaning
    // ST_CLR   | chain clear held low for 2*CLK_DIV cycles after reset
    // ST_IDLE  | ready for a frame (one cycle only with auto refresh)
    // ST_SHIFT | serial clock running, one bit per SEGCLK period
    // ST_LATCH | SEGEN high for 2*CLK_DIV cycles, then done_o
    typedef enum logic [1:0] {ST_CLR, ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

    localparam int TW = $clog2(2 * CLK_DIV) + 1;
    localparam int BW = $clog2(NBITS) + 1;
    localparam logic [TW-1:0] TMR_HALF  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TMR_FULL  = TW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(NBITS);

    state_t           state;
    logic [TW-1:0]    tmr;
    logic [BW-1:0]    bit_cnt;
    logic [NBITS-1:0] shreg;
`ifdef SEG_AUTO_REFRESH_EN
    logic [NBITS-1:0] held;
`endif

    // The register empties as it shifts, so its MSB is already 0 in LATCH and IDLE.
    assign SEGDT = shreg[NBITS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLR;
            tmr     <= TMR_FULL;
            bit_cnt <= '0;
            shreg   <= '0;
            SEGCLK  <= 1'b0;
            SEGCLR  <= 1'b0;
            SEGEN   <= 1'b0;
            ready_o <= 1'b0;
            done_o  <= 1'b0;
`ifdef SEG_AUTO_REFRESH_EN
            held    <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_CLR: begin
                    if (tmr == '0) begin
                        SEGCLR  <= 1'b1;
                        ready_o <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_IDLE: begin
`ifdef SEG_AUTO_REFRESH_EN
                    if (valid_i) begin
                        shreg <= frame_i;
                        held  <= frame_i;
                    end else begin
                        shreg <= held;
                    end
                    ready_o <= 1'b0;
                    tmr     <= TMR_HALF;
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
`else
                    if (valid_i) begin
                        shreg   <= frame_i;
                        ready_o <= 1'b0;
                        tmr     <= TMR_HALF;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
`endif
                end
                ST_SHIFT: begin
                    if (tmr == '0) begin
                        tmr    <= TMR_HALF;
                        SEGCLK <= ~SEGCLK;
                        if (SEGCLK) begin
                            shreg <= {shreg[NBITS-2:0], 1'b0};
                            if (bit_cnt == BITS_LAST) begin
                                SEGEN <= 1'b1;
                                tmr   <= TMR_FULL;
                                state <= ST_LATCH;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (tmr == '0) begin
                        SEGEN   <= 1'b0;
                        done_o  <= 1'b1;
                        ready_o <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_CLR;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: instance a uses CLK_DIV=2, instance b uses CLK_DIV=1.
module tb_seg_serial_driver;
    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic [63:0] frame_a = '0, frame_b = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ready_a, done_a, segclk_a, segclr_a, segdt_a, segen_a;
    logic        ready_b, done_b, segclk_b, segclr_b, segdt_b, segen_b;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [63:0] F0 = 64'hA5F0_0000_0000_0001;
    localparam logic [63:0] F1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] F2 = 64'hFEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    seg_serial_driver #(.CLK_DIV(2), .NBITS(64)) dut_a (
        .clk(clk), .rst(rst_a), .frame_i(frame_a), .valid_i(valid_a),
        .ready_o(ready_a), .done_o(done_a), .SEGCLK(segclk_a), .SEGCLR(segclr_a),
        .SEGDT(segdt_a), .SEGEN(segen_a));

    seg_serial_driver #(.CLK_DIV(1), .NBITS(64)) dut_b (
        .clk(clk), .rst(rst_b), .frame_i(frame_b), .valid_i(valid_b),
        .ready_o(ready_b), .done_o(done_b), .SEGCLK(segclk_b), .SEGCLR(segclr_b),
        .SEGDT(segdt_b), .SEGEN(segen_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples one frame transfer at negedges, starting with the cycle after the accept edge,
    // and stops at the first cycle with ready high.
    task automatic mon(input bit sel, input bit jam, output int rises, output int togs,
                       output logic [63:0] data, output int en_cyc, output int dn,
                       output int busy, output logic [1:0] first);
        logic pc, c, d, e, r, o;
        rises = 0; togs = 0; data = '0; en_cyc = 0; dn = 0; busy = 0; first = '0; pc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            c = sel ? segclk_b : segclk_a;
            d = sel ? segdt_b  : segdt_a;
            e = sel ? segen_b  : segen_a;
            r = sel ? ready_b  : ready_a;
            o = sel ? done_b   : done_a;
            if (jam) frame_a = {$urandom, $urandom};
            if (i == 0) first = {c, d};
            if (c !== pc) togs++;
            if (c && !pc) begin
                rises++;
                data = {data[62:0], d};
            end
            if (e) en_cyc++;
            if (o) dn++;
            pc = c;
            if (r) break;
            busy++;
        end
    endtask

    initial begin
        int rises, togs, en_cyc, dn, busy, cnt;
        logic [63:0] data;
        logic [1:0]  first;
        logic        pc;

        // Reset and chain clear
        repeat (10) @(negedge clk);
        chk("reset_a", {segclk_a, segclr_a, segdt_a, segen_a, ready_a, done_a}, 6'b0);
        chk("reset_b", {segclk_b, segclr_b, segdt_b, segen_b, ready_b, done_b}, 6'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("clr_low_%0d", k), {segclr_a, ready_a}, 2'b00);
        end
        @(negedge clk);
        chk("clr_done", {segclr_a, ready_a}, 2'b11);

`ifdef SEG_AUTO_REFRESH_EN
        // This is the single IDLE cycle: offer frame 1.
        frame_a = 64'h1;
        valid_a = 1'b1;
        @(posedge clk); #1 valid_a = 1'b0;
        mon(1'b0, 1'b0, rises, togs, data, en_cyc, dn, busy, first);
        chk("ar_first_data", data, 64'h1);
        chk("ar_first_busy", busy, 260);
        chk("ar_first_done", dn, 1);
        for (int k = 0; k < 2; k++) begin
            mon(1'b0, 1'b0, rises, togs, data, en_cyc, dn, busy, first);
            chk($sformatf("ar_refresh_data_%0d", k), data, 64'h1);
            chk($sformatf("ar_refresh_busy_%0d", k), busy, 260);
            chk($sformatf("ar_refresh_done_%0d", k), dn, 1);
        end
        frame_a = F2;
        valid_a = 1'b1;
        @(posedge clk); #1 valid_a = 1'b0;
        mon(1'b0, 1'b0, rises, togs, data, en_cyc, dn, busy, first);
        chk("ar_new_data", data, F2);
        mon(1'b0, 1'b0, rises, togs, data, en_cyc, dn, busy, first);
        chk("ar_new_refresh", data, F2);
`else
        // Single frame, CLK_DIV=2
        frame_a = F0;
        valid_a = 1'b1;
        @(posedge clk); #1 valid_a = 1'b0;
        mon(1'b0, 1'b0, rises, togs, data, en_cyc, dn, busy, first);
        chk("single_first", first, {1'b0, F0[63]});
        chk("single_rises", rises, 64);
        chk("single_data", data, F0);
        chk("single_toggles", togs, 128);
        chk("single_segen", en_cyc, 4);
        chk("single_done", dn, 1);
        chk("single_busy", busy, 260);

        // Nothing is sent while idle without a new frame
        cnt = 0; togs = 0; pc = segclk_a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (segclk_a !== pc) togs++;
            if (!ready_a) cnt++;
            pc = segclk_a;
        end
        chk("idle_quiet", {togs[31:0], cnt[31:0]}, 64'h0);

        // Back-pressure: valid held high, frame changing every cycle
        frame_a = F1;
        valid_a = 1'b1;
        @(posedge clk);
        mon(1'b0, 1'b1, rises, togs, data, en_cyc, dn, busy, first);
        chk("bp_f1_data", data, F1);
        chk("bp_f1_busy", busy, 260);
        frame_a = F2;
        mon(1'b0, 1'b1, rises, togs, data, en_cyc, dn, busy, first);
        valid_a = 1'b0;
        chk("bp_f2_first", first, {1'b0, F2[63]});
        chk("bp_f2_data", data, F2);
        chk("bp_f2_busy", busy, 260);

        // Reset at bit 30 of an all-ones frame
        @(negedge clk);
        frame_a = '1;
        valid_a = 1'b1;
        @(posedge clk); #1 valid_a = 1'b0;
        rises = 0; pc = 1'b0;
        for (int i = 0; i < 300 && rises < 30; i++) begin
            @(negedge clk);
            if (segclk_a && !pc) rises++;
            pc = segclk_a;
        end
        chk("midrst_reached", rises, 30);
        rst_a = 1'b0;
        #1;
        chk("midrst_outputs", {segclk_a, segclr_a, segdt_a, segen_a, ready_a, done_a}, 6'b0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_clr_low", {segclr_a, ready_a}, 2'b00);
        @(negedge clk);
        chk("midrst_clr_done", {segclr_a, ready_a}, 2'b11);
        togs = 0; cnt = 0; pc = segclk_a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (segclk_a !== pc) togs++;
            if (segdt_a || segen_a) cnt++;
            pc = segclk_a;
        end
        chk("midrst_no_residue", {togs[31:0], cnt[31:0]}, 64'h0);

        // CLK_DIV=1 boundary on instance b
        frame_b = '1;
        valid_b = 1'b1;
        @(posedge clk); #1 valid_b = 1'b0;
        mon(1'b1, 1'b0, rises, togs, data, en_cyc, dn, busy, first);
        chk("div1_rises", rises, 64);
        chk("div1_data", data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div1_toggles", togs, 128);
        chk("div1_busy", busy, 130);
        chk("div1_segen", en_cyc, 2);
        chk("div1_done", dn, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
